// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin arbiter for a shared UART transmitter
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   req_valid     per-port byte pending (held with req_data/req_last until req_ack)
//   req_data      per-port byte, port i at [8*i+7:8*i]
//   req_last      per-port end-of-packet flag for the presented byte
//   req_ack       one-cycle pulse, byte accepted (always coincides with uart_tx_en)
//   uart_tx_data  byte to the UART, valid with uart_tx_en
//   uart_tx_en    one-cycle start-transmit pulse
//   uart_tx_done  UART finished the current byte
//   owner         current or last granted port
//   busy          arbiter not idle
//   timeout_err   one-cycle pulse when a locked owner is dropped for inactivity

module uart_tx_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int TIMEOUT    = 50000,
    parameter int OWNER_BITS = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_PORTS-1:0]   req_valid,
    input  logic [8*NUM_PORTS-1:0] req_data,
    input  logic [NUM_PORTS-1:0]   req_last,
    output logic [NUM_PORTS-1:0]   req_ack,
    output logic [7:0]             uart_tx_data,
    output logic                   uart_tx_en,
    input  logic                   uart_tx_done,
    output logic [OWNER_BITS-1:0]  owner,
    output logic                   busy,
    output logic                   timeout_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        LOCKED    = 2'd2
    } state_t;

    state_t                state;
    logic [OWNER_BITS-1:0] last_owner;
    logic                  last_lat;
    logic [31:0]           timer;

    logic [OWNER_BITS-1:0] winner;
    logic [OWNER_BITS-1:0] sel;
    logic [NUM_PORTS-1:0]  sel_onehot;
    logic [7:0]            sel_data;
    logic                  sel_last;
    logic                  owner_valid;
    logic                  found;
    logic                  issue;

    // Round-robin search starting just after last_owner: first the ports
    // above it in ascending order, then wrap around to the ports at or below it.
    always_comb begin
        winner = last_owner;
        found  = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found && req_valid[i] && (OWNER_BITS'(i) > last_owner)) begin
                winner = OWNER_BITS'(i);
                found  = 1'b1;
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found && req_valid[i] && (OWNER_BITS'(i) <= last_owner)) begin
                winner = OWNER_BITS'(i);
                found  = 1'b1;
            end
        end
    end

    // In IDLE the round-robin winner is served; while locked only the owner is.
    always_comb begin
        sel         = (state == IDLE) ? winner : owner;
        sel_onehot  = '0;
        sel_data    = 8'h00;
        sel_last    = 1'b0;
        owner_valid = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (OWNER_BITS'(i) == owner) begin
                owner_valid = req_valid[i];
            end
            if (OWNER_BITS'(i) == sel) begin
                sel_onehot[i] = 1'b1;
                sel_data      = req_data[8*i +: 8];
                sel_last      = req_last[i];
            end
        end
        issue = ((state == IDLE) && (|req_valid)) || ((state == LOCKED) && owner_valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_owner   <= OWNER_BITS'(NUM_PORTS - 1);
            last_lat     <= 1'b0;
            timer        <= 32'd0;
            req_ack      <= '0;
            uart_tx_data <= 8'h00;
            uart_tx_en   <= 1'b0;
            owner        <= '0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            req_ack     <= '0;
            uart_tx_en  <= 1'b0;
            timeout_err <= 1'b0;
            if (issue) begin
                uart_tx_en   <= 1'b1;
                uart_tx_data <= sel_data;
                req_ack      <= sel_onehot;
                owner        <= sel;
                last_lat     <= sel_last;
                state        <= WAIT_DONE;
                busy         <= 1'b1;
            end else begin
                case (state)
                    WAIT_DONE: begin
                        if (uart_tx_done) begin
                            if (last_lat) begin
                                state      <= IDLE;
                                busy       <= 1'b0;
                                last_owner <= owner;
                            end else begin
                                state <= LOCKED;
                                timer <= 32'd0;
                            end
                        end
                    end
                    LOCKED: begin
                        // A byte arriving on the expiry cycle is taken by the
                        // issue branch above, so it always beats the timeout.
                        if (timer == 32'(TIMEOUT - 1)) begin
                            timeout_err <= 1'b1;
                            state       <= IDLE;
                            busy        <= 1'b0;
                            last_owner  <= owner;
                        end else begin
                            timer <= timer + 32'd1;
                        end
                    end
                    IDLE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter

module tb_uart_tx_arbiter;
    localparam int NP = 3;
    localparam int TO = 100;
    localparam int OB = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NP-1:0]   req_valid;
    logic [8*NP-1:0] req_data;
    logic [NP-1:0]   req_last;
    logic [NP-1:0]   req_ack;
    logic [7:0]      uart_tx_data;
    logic            uart_tx_en;
    logic            uart_tx_done;
    logic [OB-1:0]   owner;
    logic            busy;
    logic            timeout_err;

    uart_tx_arbiter #(.NUM_PORTS(NP), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ack(req_ack),
        .uart_tx_data(uart_tx_data), .uart_tx_en(uart_tx_en), .uart_tx_done(uart_tx_done),
        .owner(owner), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // per-port byte queues: data, last flag, idle gap before presenting
    logic [7:0] pd [NP][64];
    logic       pl [NP][64];
    int         pg [NP][64];
    int         pres_cyc [NP][64];
    int         head [NP];
    int         tail [NP];
    int         gap_left [NP];
    bit         pop_next [NP];

    // UART model
    int done_cnt = 0;
    int uart_dly = 3;
    bit rand_dly = 0;
    bit spur     = 0;
    bit in_flight = 0;

    // event log
    int         ev_cyc  [256];
    int         ev_port [256];
    int         ev_pres [256];
    int         ev_done [256];
    logic [7:0] ev_data [256];
    int         ev_n = 0;
    int         to_cyc [8];
    int         to_n = 0;
    int         busy_fall = -1;
    bit         prev_busy = 0;

    // transaction-level expectations
    bit            pkt_open = 0;
    int            pkt_port = 0;
    int            last_pkt_owner = NP - 1;
    logic [NP-1:0] prev_valid = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NP-1:0] v, input int lo);
        for (int k = 1; k <= NP; k++) begin
            if (v[(lo + k) % NP]) return (lo + k) % NP;
        end
        return -1;
    endfunction

    task automatic cycle();
        int p;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            pkt_open = 0;
            last_pkt_owner = NP - 1;
        end
        check("ack_onehot", 32'($onehot0(req_ack)), 32'd1);
        check("ack_with_en", 32'(req_ack != '0), 32'(uart_tx_en));
        if (uart_tx_en) begin
            p = 0;
            for (int i = NP - 1; i >= 0; i--) if (req_ack[i]) p = i;
            check("no_overlap", 32'(in_flight), 32'd0);
            check("tx_data", 32'(uart_tx_data), 32'(pd[p][head[p]]));
            check("owner", 32'(owner), p);
            if (pkt_open) check("lock_port", p, pkt_port);
            else          check("rr_pick", p, rr_pick(prev_valid, last_pkt_owner));
            if (pl[p][head[p]]) begin
                pkt_open = 0;
                last_pkt_owner = p;
            end else begin
                pkt_open = 1;
                pkt_port = p;
            end
            if (ev_n < 256) begin
                ev_cyc[ev_n]  = cyc;
                ev_port[ev_n] = p;
                ev_data[ev_n] = uart_tx_data;
                ev_pres[ev_n] = pres_cyc[p][head[p]];
                ev_n++;
            end
            in_flight = 1;
        end
        if (timeout_err) begin
            check("timeout_locked", 32'(pkt_open), 32'd1);
            pkt_open = 0;
            last_pkt_owner = pkt_port;
            if (to_n < 8) to_cyc[to_n] = cyc;
            to_n++;
        end
        if (prev_busy && !busy) busy_fall = cyc;
        prev_busy = busy;

        uart_tx_done = 1'b0;
        if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) begin
                uart_tx_done = 1'b1;
                in_flight = 0;
                if (ev_n > 0) ev_done[ev_n - 1] = cyc;
            end
        end
        if (uart_tx_en) done_cnt = rand_dly ? int'($urandom_range(1, 6)) : uart_dly;
        if (spur) begin
            uart_tx_done = 1'b1;
            spur = 0;
        end

        for (int i = 0; i < NP; i++) begin
            if (pop_next[i]) begin
                pop_next[i] = 0;
                head[i]++;
                req_valid[i] = 1'b0;
                gap_left[i] = (head[i] < tail[i]) ? pg[i][head[i]] : 0;
            end
            if (req_ack[i] && req_valid[i]) pop_next[i] = 1;
            if (!req_valid[i] && head[i] < tail[i]) begin
                if (gap_left[i] == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[8*i +: 8] = pd[i][head[i]];
                    req_last[i] = pl[i][head[i]];
                    pres_cyc[i][head[i]] = cyc;
                end else begin
                    gap_left[i]--;
                end
            end
        end
        prev_valid = req_valid;
    endtask

    task automatic push(input int p, input logic [7:0] d, input logic l, input int g);
        if (head[p] == tail[p]) gap_left[p] = g;
        pd[p][tail[p]] = d;
        pl[p][tail[p]] = l;
        pg[p][tail[p]] = g;
        tail[p]++;
    endtask

    function automatic bit drained();
        for (int i = 0; i < NP; i++) if (head[i] != tail[i]) return 0;
        return !busy && !in_flight;
    endfunction

    task automatic wait_events(input int n, input int limit, input string tag);
        int k = 0;
        while (ev_n < n && k < limit) begin
            cycle();
            k++;
        end
        check({tag, "_events"}, 32'(ev_n >= n), 32'd1);
    endtask

    task automatic wait_drain(input int limit, input string tag);
        int k = 0;
        while (!drained() && k < limit) begin
            cycle();
            k++;
        end
        check({tag, "_drain"}, 32'(drained()), 32'd1);
    endtask

    task automatic wait_done(input int limit);
        int k = 0;
        while (in_flight && k < limit) begin
            cycle();
            k++;
        end
        check("uart_done_seen", 32'(in_flight), 32'd0);
    endtask

    task automatic clear_log();
        ev_n = 0;
        to_n = 0;
        busy_fall = -1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < NP; i++) begin
            head[i] = 0;
            tail[i] = 0;
            gap_left[i] = 0;
            pop_next[i] = 0;
        end
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
    endtask

    initial begin
        int nb;
        int len;
        rst = 1'b1;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        uart_tx_done = 1'b0;
        for (int i = 0; i < NP; i++) begin
            head[i] = 0;
            tail[i] = 0;
            gap_left[i] = 0;
            pop_next[i] = 0;
        end

        // reset values
        cycle();
        check("rst_tx_en", 32'(uart_tx_en), 32'd0);
        check("rst_ack", 32'(req_ack), 32'd0);
        check("rst_data", 32'(uart_tx_data), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        rst = 1'b0;
        cycle();

        // single packet on port 0, UART takes 10 cycles per byte
        do_reset();
        clear_log();
        uart_dly = 10;
        push(0, 8'h41, 1'b0, 0);
        push(0, 8'h42, 1'b0, 12);
        push(0, 8'h43, 1'b1, 12);
        wait_events(3, 200, "t1");
        wait_drain(100, "t1");
        check("t1_count", ev_n, 3);
        for (int i = 0; i < 3; i++) begin
            check("t1_data", 32'(ev_data[i]), 32'h41 + i);
            check("t1_port", ev_port[i], 0);
            check("t1_latency", ev_cyc[i] - ev_pres[i], 1);
        end
        check("t1_busy_fall", busy_fall, ev_done[2] + 1);
        check("t1_owner", 32'(owner), 32'd0);

        // contention: ports 0 and 1 stream one-byte packets back to back
        do_reset();
        clear_log();
        uart_dly = 3;
        for (int i = 0; i < 4; i++) begin
            push(0, 8'hA0, 1'b1, 0);
            push(1, 8'hB1, 1'b1, 0);
        end
        wait_events(8, 200, "t2");
        wait_drain(100, "t2");
        for (int i = 0; i < 8; i++) begin
            check("t2_port", ev_port[i], i % 2);
            check("t2_data", 32'(ev_data[i]), (i % 2 == 1) ? 32'hB1 : 32'hA0);
        end

        // lock hold: port 1 waits for the whole port-0 packet
        do_reset();
        clear_log();
        uart_dly = 3;
        push(0, 8'h10, 1'b0, 0);
        push(0, 8'h11, 1'b0, 20);
        push(0, 8'h12, 1'b0, 20);
        push(0, 8'h13, 1'b1, 20);
        wait_events(1, 50, "t3a");
        push(1, 8'hC5, 1'b1, 0);
        wait_events(5, 300, "t3b");
        wait_drain(100, "t3");
        for (int i = 0; i < 4; i++) check("t3_owner_port", ev_port[i], 0);
        check("t3_p1_port", ev_port[4], 1);
        check("t3_p1_data", 32'(ev_data[4]), 32'hC5);
        check("t3_p1_cycle", ev_cyc[4], ev_done[3] + 2);

        // timeout: port 0 leaves its packet open, port 1 pending
        do_reset();
        clear_log();
        uart_dly = 5;
        push(0, 8'h55, 1'b0, 0);
        push(1, 8'h66, 1'b1, 0);
        wait_events(2, 300, "t4a");
        push(0, 8'h77, 1'b1, 0);
        push(2, 8'h88, 1'b1, 0);
        wait_events(4, 100, "t4b");
        wait_drain(100, "t4");
        check("t4_to_count", to_n, 1);
        check("t4_to_cycle", to_cyc[0], ev_done[0] + 1 + TO);
        check("t4_p1_port", ev_port[1], 1);
        check("t4_p1_cycle", ev_cyc[1], to_cyc[0] + 1);
        check("t4_p1_data", 32'(ev_data[1]), 32'h66);
        check("t4_rr_next", ev_port[2], 2);
        check("t4_rr_last", ev_port[3], 0);

        // reset in the middle of a packet, stray tx_done afterwards
        do_reset();
        clear_log();
        uart_dly = 10;
        push(0, 8'h30, 1'b1, 0);
        wait_events(1, 50, "t5a");
        wait_drain(100, "t5a");
        push(0, 8'h31, 1'b0, 0);
        wait_events(2, 50, "t5b");
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("t5_rst_tx_en", 32'(uart_tx_en), 32'd0);
        check("t5_rst_ack", 32'(req_ack), 32'd0);
        check("t5_rst_data", 32'(uart_tx_data), 32'd0);
        check("t5_rst_owner", 32'(owner), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_timeout", 32'(timeout_err), 32'd0);
        wait_done(30);
        cycle();
        cycle();
        check("t5_stray_busy", 32'(busy), 32'd0);
        check("t5_stray_events", ev_n, 2);
        push(1, 8'hD1, 1'b1, 0);
        push(0, 8'hD0, 1'b1, 0);
        wait_events(4, 100, "t5c");
        wait_drain(100, "t5");
        check("t5_prio_port", ev_port[2], 0);
        check("t5_prio_data", 32'(ev_data[2]), 32'hD0);
        check("t5_next_port", ev_port[3], 1);

        // spurious tx_done in IDLE and in LOCKED
        do_reset();
        clear_log();
        spur = 1;
        cycle();
        cycle();
        cycle();
        check("t6_idle_busy", 32'(busy), 32'd0);
        check("t6_idle_events", ev_n, 0);
        uart_dly = 4;
        push(0, 8'h61, 1'b0, 0);
        wait_events(1, 50, "t6a");
        wait_done(30);
        for (int i = 0; i < 10; i++) cycle();
        spur = 1;
        cycle();
        for (int i = 0; i < 20; i++) cycle();
        spur = 1;
        cycle();
        cycle();
        check("t6_lock_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 200 && to_n == 0; i++) cycle();
        check("t6_to_count", to_n, 1);
        check("t6_to_cycle", to_cyc[0], ev_done[0] + 1 + TO);
        check("t6_events", ev_n, 1);

        // randomized packets on all ports with random UART latency
        do_reset();
        clear_log();
        rand_dly = 1;
        nb = 0;
        for (int p = 0; p < NP; p++) begin
            for (int k = 0; k < 6; k++) begin
                len = int'($urandom_range(1, 4));
                for (int b = 0; b < len; b++) begin
                    push(p, 8'($urandom), 1'(b == len - 1), int'($urandom_range(0, 5)));
                    nb++;
                end
            end
        end
        wait_drain(5000, "rand");
        check("rand_count", ev_n, nb);
        check("rand_no_timeout", to_n, 0);
        rand_dly = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
